sv_inv_engine: RTL and testbench
================================

// Module: sv_inv_engine
// PURPOSE
//  Sequential modular inverter: out = a^-1 mod q, for odd q, via the binary extended Euclid algorithm.
//  Performs one reduction step per clock (halve-u / halve-v / subtract) and flags non-invertible inputs.
//  Sits between the point-arithmetic scheduler and the field datapath.
//  Uses valid/ready handshakes on both input and output.
// PARAMETERS
//  DATA_WIDTH  128             operand width W; q, a and the result are all W bits
//  MAX_ITER    4*DATA_WIDTH+4  watchdog limit on RUN steps; exceeding it raises err
// PORTS
//  clk_i        in   1  clock, rising edge
//  rst_ni       in   1  asynchronous reset, active low
//  in_valid_i   in   1  q_i/a_i valid
//  in_ready_o   out  1  engine idle, can accept
//  q_i          in   W  modulus; must be odd and >1
//  a_i          in   W  operand; must satisfy 0 < a < q
//  out_valid_o  out  1  result/err valid; held until accepted
//  out_ready_i  in   1  consumer accepts result
//  inv_o        out  W  a^-1 mod q; 0 when err_o=1
//  err_o        out  1  input illegal, gcd(a,q)!=1, or watchdog expired
// BEHAVIOUR
//  Reset (async, rst_ni=0): state=IDLE; in_ready_o=1; out_valid_o=0; inv_o=0; err_o=0; all regs cleared.
//   Reset mid-RUN/DONE aborts the operation; no output is produced for it.
//  FSM IDLE -> RUN -> DONE -> IDLE. in_ready_o=1 only in IDLE; out_valid_o=1 only in DONE.
//  IDLE: on in_valid_i, latch q=q_i, u=a_i, v=q_i, x1=1, x2=0, iter=0; go to RUN.
//   Latch err_pre=1 if q_i[0]==0, q_i<=1, a_i==0 or a_i>=q_i.
//  RUN, one action per cycle, first matching rule wins:
//   1) err_pre or iter==MAX_ITER   -> DONE, err=1
//   2) u==1                        -> DONE, res=x1
//   3) v==1                        -> DONE, res=x2
//   4) u==0 or v==0                -> DONE, err=1 (gcd>1)
//   5) u even: u=u>>1; x1 = x1 even ? x1>>1 : (x1+q)>>1
//   6) v even: v=v>>1; x2 halved the same way
//   7) u>=v: u=u-v; x1=x1-x2, +q on borrow; else v=v-u; x2=x2-x1, +q on borrow
//   iter increments on every step (rules 5-7).
//  Width rules:
//   - (x+q) is computed in W+1 bits; the halved result is sum[W:1].
//   - Modular subtraction is computed in W+1 bits; a borrow selects diff+q.
//   - Invariants: x1,x2 in [0,q); u,v <= q.
//  DONE: inv_o=res (0 on err), err_o=err. Both are stable while out_valid_o=1 and out_ready_i=0.
//   On out_ready_i: go to IDLE, out_valid_o drops next cycle.
//   in_ready_o rises in that same next cycle; there is no accept/complete overlap.
//  Latency: accept at cycle N -> out_valid_o at N+2+steps. Worst case is <= MAX_ITER+2.
//  in_valid_i is ignored outside IDLE; input changes while busy have no effect.
//  out_ready_i is ignored outside DONE.
// TESTING
//  T1: q=7, a=3 -> 3 steps; out_valid_o 5 cycles after accept; inv_o=5, err_o=0.
//  T2: q=13, a=1 -> out_valid_o 2 cycles after accept; inv_o=1.
//  T3: q=15, a=5 -> err_o=1, inv_o=0. Also a=0, a=q, and q=16 each -> err_o=1.
//  T4: W=128, q=2^127-1, a=2 -> inv_o=2^126; random odd q/a pairs checked against a model: a*inv mod q == 1.
//  T5: hold out_ready_i=0 for 10 cycles in DONE -> inv_o/err_o stable, in_ready_o=0; release -> IDLE next cycle.
//  T6: assert rst_ni=0 mid-RUN -> outputs at reset values immediately; next op (q=7, a=3) -> inv_o=5.

Source files
------------

// File: rtl/sv_inv_engine.sv
// Sequential modular inverter: inv = a^-1 mod q (q odd) via binary extended Euclid,
// one halve/subtract step per clock, with valid/ready handshakes on both sides.
//
// state  | meaning
// S_IDLE | ready for a new q/a pair
// S_RUN  | one reduction step (or termination check) per cycle
// S_DONE | result/err presented until out_ready_i
module sv_inv_engine #(
  parameter int DATA_WIDTH = 128,
  parameter int MAX_ITER   = 4*DATA_WIDTH+4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] q_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] inv_o,
  output logic                  err_o
);

  localparam int W  = DATA_WIDTH;
  localparam int IW = $clog2(MAX_ITER+1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state, state_d;
  logic [W-1:0]   q, q_d, u, u_d, v, v_d, x1, x1_d, x2, x2_d, res, res_d;
  logic [IW-1:0]  iter, iter_d;
  logic           err_pre, err_pre_d, err, err_d;

  // x/2 mod q for odd q: add q first when x is odd, keep the carry bit
  function automatic logic [W-1:0] half_mod(input logic [W-1:0] x, input logic [W-1:0] m);
    logic [W:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return s[W:1];
  endfunction

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] m);
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    return d[W] ? (d[W-1:0] + m) : d[W-1:0];
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= S_IDLE;
      q       <= '0;
      u       <= '0;
      v       <= '0;
      x1      <= '0;
      x2      <= '0;
      res     <= '0;
      iter    <= '0;
      err_pre <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      q       <= q_d;
      u       <= u_d;
      v       <= v_d;
      x1      <= x1_d;
      x2      <= x2_d;
      res     <= res_d;
      iter    <= iter_d;
      err_pre <= err_pre_d;
      err     <= err_d;
    end
  end

  always_comb begin
    state_d   = state;
    q_d       = q;
    u_d       = u;
    v_d       = v;
    x1_d      = x1;
    x2_d      = x2;
    res_d     = res;
    iter_d    = iter;
    err_pre_d = err_pre;
    err_d     = err;
    case (state)
      S_IDLE: begin
        if (in_valid_i) begin
          q_d       = q_i;
          u_d       = a_i;
          v_d       = q_i;
          x1_d      = W'(1);
          x2_d      = '0;
          iter_d    = '0;
          res_d     = '0;
          err_d     = 1'b0;
          err_pre_d = !q_i[0] || (q_i <= W'(1)) || (a_i == '0) || (a_i >= q_i);
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (err_pre || (iter == IW'(MAX_ITER))) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = S_DONE;
        end else if (u == W'(1)) begin
          res_d   = x1;
          state_d = S_DONE;
        end else if (v == W'(1)) begin
          res_d   = x2;
          state_d = S_DONE;
        end else if ((u == '0) || (v == '0)) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = S_DONE;
        end else begin
          iter_d = iter + IW'(1);
          if (!u[0]) begin
            u_d  = u >> 1;
            x1_d = half_mod(x1, q);
          end else if (!v[0]) begin
            v_d  = v >> 1;
            x2_d = half_mod(x2, q);
          end else if (u >= v) begin
            u_d  = u - v;
            x1_d = sub_mod(x1, x2, q);
          end else begin
            v_d  = v - u;
            x2_d = sub_mod(x2, x1, q);
          end
        end
      end
      S_DONE: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready_o  = (state == S_IDLE);
  assign out_valid_o = (state == S_DONE);
  assign inv_o       = res;
  assign err_o       = err;

endmodule

// File: tb/tb_sv_inv_engine.sv
// Self-checking bench for sv_inv_engine: directed vector table, handshake/reset
// sequences, and random operands checked against an extended-Euclid model.
module tb_sv_inv_engine;

  localparam int W        = 128;
  localparam int MAX_ITER = 4*W+4;
  localparam int LIMIT    = MAX_ITER + 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, err;
  logic [W-1:0] q_in, a_in, inv;

  int n_checks = 0;
  int n_fail   = 0;

  sv_inv_engine #(.DATA_WIDTH(W), .MAX_ITER(MAX_ITER)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .q_i(q_in), .a_i(a_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .inv_o(inv), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] a;
    logic [W-1:0] inv;
    logic         err;
    int           lat;   // 0 = latency not checked
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic [W-1:0] q, input logic [W-1:0] a,
                         input logic [W-1:0] inv_e, input logic err_e, input int lat);
    vec_t v;
    v.q = q; v.a = a; v.inv = inv_e; v.err = err_e; v.lat = lat;
    vecs.push_back(v);
  endtask

  // reference: classic extended Euclid with coefficients kept modulo q
  task automatic model_inv(input logic [W-1:0] q, input logic [W-1:0] a,
                           output logic [W-1:0] inv_e, output logic err_e);
    logic [2*W-1:0] r, nr, t, nt, quo, tmp, qq;
    inv_e = '0;
    err_e = 1'b0;
    if (!q[0] || q <= 1 || a == 0 || a >= q) begin
      err_e = 1'b1;
      return;
    end
    qq = {{W{1'b0}}, q};
    r = qq; nr = {{W{1'b0}}, a}; t = '0; nt = 1;
    while (nr != 0) begin
      quo = r / nr;
      tmp = (t + qq - ((quo * nt) % qq)) % qq;
      t = nt; nt = tmp;
      tmp = r - quo * nr;
      r = nr; nr = tmp;
    end
    if (r != 1) err_e = 1'b1;
    else        inv_e = t[W-1:0];
  endtask

  // present q/a for one accept edge, then wait for out_valid; lat counts the accept edge as 1
  task automatic issue(input logic [W-1:0] q, input logic [W-1:0] a, input logic keep_valid,
                       output int lat, output logic [W-1:0] inv_g, output logic err_g);
    @(negedge clk);
    in_valid = 1'b1; q_in = q; a_in = a;
    @(posedge clk); #1;
    if (keep_valid) begin
      q_in = 128'd9; a_in = 128'd4;
    end else begin
      in_valid = 1'b0;
    end
    lat = 1;
    while (!out_valid && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: no out_valid after %0d cycles (q=%0h a=%0h)", lat, q, a);
    end
    inv_g = inv;
    err_g = err;
  endtask

  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [W-1:0] m127, inv_g, inv_e, inv_h;
  logic         err_g, err_e, err_h;
  logic [2*W-1:0] prod;
  int           lat;
  logic         stable;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; q_in = '0; a_in = '0;
    m127 = (128'd1 << 127) - 128'd1;

    add_vec(128'd7,  128'd3, 128'd5, 1'b0, 5);
    add_vec(128'd13, 128'd1, 128'd1, 1'b0, 2);
    add_vec(128'd15, 128'd5, 128'd0, 1'b1, 0);
    add_vec(128'd7,  128'd0, 128'd0, 1'b1, 2);
    add_vec(128'd7,  128'd7, 128'd0, 1'b1, 2);
    add_vec(128'd16, 128'd3, 128'd0, 1'b1, 2);
    add_vec(128'd1,  128'd0, 128'd0, 1'b1, 2);
    add_vec(128'd7,  128'd6, 128'd6, 1'b0, 0);
    add_vec(128'd11, 128'd2, 128'd6, 1'b0, 0);
    add_vec(m127,    128'd2, 128'd1 << 126, 1'b0, 0);

    #12;
    check("reset in_ready",  {127'd0, in_ready},  128'd1);
    check("reset out_valid", {127'd0, out_valid}, 128'd0);
    check("reset inv",       inv,                 128'd0);
    check("reset err",       {127'd0, err},       128'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].q, vecs[i].a, 1'b0, lat, inv_g, err_g);
      check($sformatf("vec%0d inv", i), inv_g, vecs[i].inv);
      check($sformatf("vec%0d err", i), {127'd0, err_g}, {127'd0, vecs[i].err});
      if (vecs[i].lat != 0)
        check($sformatf("vec%0d latency", i), 128'(lat), 128'(vecs[i].lat));
      check($sformatf("vec%0d in_ready in DONE", i), {127'd0, in_ready}, 128'd0);
      accept();
      check($sformatf("vec%0d out_valid after accept", i), {127'd0, out_valid}, 128'd0);
      check($sformatf("vec%0d in_ready after accept", i), {127'd0, in_ready}, 128'd1);
    end

    // inputs changing while busy must not disturb the operation
    issue(128'd7, 128'd3, 1'b1, lat, inv_g, err_g);
    check("busy-change inv", inv_g, 128'd5);
    check("busy-change latency", 128'(lat), 128'd5);
    accept();

    // hold the result in DONE for 10 cycles
    issue(128'd7, 128'd3, 1'b0, lat, inv_h, err_h);
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (inv !== inv_h || err !== err_h || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    check("hold stable", {127'd0, stable}, 128'd1);
    check("hold inv", inv, 128'd5);
    accept();
    check("hold release in_ready", {127'd0, in_ready}, 128'd1);

    // reset in the middle of a long run
    @(negedge clk);
    in_valid = 1'b1; q_in = m127; a_in = 128'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrun reset in_ready",  {127'd0, in_ready},  128'd1);
    check("midrun reset out_valid", {127'd0, out_valid}, 128'd0);
    check("midrun reset inv",       inv,                 128'd0);
    @(negedge clk); rst_n = 1'b1;
    issue(128'd7, 128'd3, 1'b0, lat, inv_g, err_g);
    check("post-reset inv", inv_g, 128'd5);
    check("post-reset err", {127'd0, err_g}, 128'd0);
    accept();

    // random operands against the model
    for (int k = 0; k < 24; k++) begin
      logic [W-1:0] qr, ar;
      qr = {$urandom, $urandom, $urandom, $urandom} | 128'd1;
      if (k < 8) qr = qr & 128'hffff;
      if (qr <= 128'd1) qr = 128'd3;
      ar = {$urandom, $urandom, $urandom, $urandom} % qr;
      if (ar == 0) ar = 128'd1;
      model_inv(qr, ar, inv_e, err_e);
      issue(qr, ar, 1'b0, lat, inv_g, err_g);
      check($sformatf("rnd%0d inv", k), inv_g, inv_e);
      check($sformatf("rnd%0d err", k), {127'd0, err_g}, {127'd0, err_e});
      if (!err_e) begin
        prod = ({{W{1'b0}}, ar} * {{W{1'b0}}, inv_g}) % {{W{1'b0}}, qr};
        check($sformatf("rnd%0d a*inv mod q", k), prod[W-1:0], 128'd1);
      end
      check($sformatf("rnd%0d latency bound", k), 128'(lat <= MAX_ITER + 2), 128'd1);
      accept();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
